// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Adds two WIDTH-bit operands plus a carry-in with a single full-adder cell,
// one bit per clock, LSB first. The carry between bit positions lives in a flop.
// A start/done handshake faces the requester. S/Cout are registered and change
// only alongside the done pulse. Legal WIDTH range is 1..32.

// One-bit full adder: the only arithmetic in the block.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // Wide enough to hold the value WIDTH, which the counter reaches on the
  // final bit.
  localparam int CW = $clog2(WIDTH + 1);
  // Count value while the MSB is being processed.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;

  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH:0]   res_wide;
  logic [WIDTH-1:0] res_next;

  // The single full-adder cell sees the current LSBs and the carry flop.
  fa_cell u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // A start request is taken only in IDLE. Requests in RUN or DONE are dropped.
  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (count_q == LAST);

  // The new sum bit enters at the MSB, and the older bits move toward the LSB.
  // Widening first keeps the shift valid for WIDTH=1, where there are no older
  // bits.
  assign res_wide = {fa_s, res_q} >> 1;
  assign res_next = res_wide[WIDTH-1:0];

  // Both handshake outputs are decoded from the state flop, so they are glitch-free.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB,
  // and DONE always returns to IDLE after one cycle.
  // NOTE: state_d gets a default before the case. A path that does not
  // assign it would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Serial datapath: load the operands on accept, then do one bit per RUN cycle.
  // NOTE: all datapath registers clear on reset. An aborted operation then
  // leaves nothing behind that a later operation could pick up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      op_a_q  <= A;
      op_b_q  <= B;
      carry_q <= Cin;
      count_q <= '0;
    end else if (state_q == RUN) begin
      op_a_q  <= op_a_q >> 1;
      op_b_q  <= op_b_q >> 1;
      res_q   <= res_next;
      carry_q <= fa_cout;
      count_q <= count_q + 1'b1;
    end
  end

  // Result registers: they keep the previous result throughout RUN and
  // update only on the edge that processes the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else if (last_bit) begin
      S    <= res_next;
      Cout <= fa_cout;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. It drives a WIDTH=8 instance and a WIDTH=1
// instance from the same clock and reset. Expected results and timing come
// from plain arithmetic and cycle counts.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] s8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       cout1;

  int tests = 0;
  int fails = 0;

  // Last result the WIDTH=8 instance should be presenting.
  logic [7:0] prev_s    = 8'h00;
  logic       prev_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .S     (s8),
    .Cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .S     (s1),
    .Cout  (cout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one WIDTH=8 operation. Checks latency, busy length, S/Cout holding
  // during RUN, and the final sum. If glitch_c is nonzero, start is pulsed
  // with other operands at that RUN sample, and A/B are scrambled afterwards.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input int glitch_c, input string tag);
    logic [8:0] exp_sum;
    int busy_cnt;
    int done_c;
    exp_sum  = 9'(a) + 9'(b) + 9'(cin);
    busy_cnt = 0;
    done_c   = 0;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_c = c;
        break;
      end
      check({tag, "_hold_s"}, 64'(s8), 64'(prev_s));
      check({tag, "_hold_cout"}, 64'(cout8), 64'(prev_cout));
      if (glitch_c != 0 && c == glitch_c) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else if (glitch_c != 0 && c == glitch_c + 1) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_cycle"}, 64'(done_c), 64'd9);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
    check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
    check({tag, "_s"}, 64'(s8), 64'(exp_sum[7:0]));
    check({tag, "_cout"}, 64'(cout8), 64'(exp_sum[8]));
    prev_s    = exp_sum[7:0];
    prev_cout = exp_sum[8];
    start8 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_clear"}, 64'(done8), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy8), 64'd0);
  endtask

  logic [7:0] ba [40];
  logic [7:0] bb [40];
  logic       bc [40];
  logic [8:0] bsum;
  logic       prev_done;
  logic [2:0] v;
  logic [1:0] sum1;

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state
    #1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_s", 64'(s8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations from the plan
    op8(8'h5A, 8'h33, 1'b0, 0, "op_5a_33");
    op8(8'hFF, 8'h01, 1'b0, 0, "op_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 0, "op_ff_ff_1");
    op8(8'h00, 8'h00, 1'b0, 0, "op_zero");

    // Busy guard: a start pulse during RUN plus operand changes
    op8(8'h10, 8'h01, 1'b0, 3, "guard");
    check("guard_s_value", 64'(s8), 64'h11);

    // Randomized operations
    for (int i = 0; i < 8; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
    end

    // Reset mid-operation
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_s", 64'(s8), 64'd0);
    check("midrst_cout", 64'(cout8), 64'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    prev_s = 8'h00; prev_cout = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 64'(done8), 64'd0);
    end
    op8(8'h01, 8'h02, 1'b0, 0, "after_rst");

    // Back-to-back: start held high. Accepts land on every tenth edge.
    for (int e = 0; e < 40; e++) begin
      ba[e] = 8'($urandom); bb[e] = 8'($urandom); bc[e] = 1'($urandom);
    end
    prev_done = 1'b0;
    for (int e = 0; e < 40; e++) begin
      start8 = 1'b1; a8 = ba[e]; b8 = bb[e]; cin8 = bc[e];
      @(posedge clk); #1;
      check("b2b_done", 64'(done8), 64'((e % 10) == 8));
      check("b2b_no_consec", 64'(prev_done & done8), 64'd0);
      if ((e % 10) == 8) begin
        bsum = 9'(ba[e-8]) + 9'(bb[e-8]) + 9'(bc[e-8]);
        check("b2b_s", 64'(s8), 64'(bsum[7:0]));
        check("b2b_cout", 64'(cout8), 64'(bsum[8]));
        prev_s = bsum[7:0]; prev_cout = bsum[8];
      end
      prev_done = done8;
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", 64'(busy8), 64'd0);

    // WIDTH=1 sweep over the full-adder truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      sum1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
      check("w1_busy", 64'(busy1), 64'd1);
      check("w1_done_early", 64'(done1), 64'd0);
      @(posedge clk); #1;
      check("w1_done", 64'(done1), 64'd1);
      check("w1_s", 64'(s1), 64'(sum1[0]));
      check("w1_cout", 64'(cout1), 64'(sum1[1]));
      @(posedge clk); #1;
      check("w1_done_clear", 64'(done1), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
